// File: rtl/dvp_byte_pack.sv
// ----------------------------------------------------------------------------
// dvp_byte_pack
// Pairs consecutive DVP bytes into one 16-bit RGB565 word. The first byte of
// a pair is the high byte (R[4:0] G[5:3]) and the second is the low byte
// (G[2:0] B[4:0]). The formed word and its strobe are combinational on the
// second byte, so the parent can register them with its own qualifiers.
//
// Ports:
//   clk      pixel clock
//   rst_n    asynchronous active-low reset
//   clear    forces the pairing back to the high-byte phase
//   en       a valid byte is present on data this cycle
//   data     registered DVP byte
//   pix      {high byte, current byte}, meaningful when pix_stb is set
//   pix_stb  second byte of a pair is present this cycle
//   phase    0 = expecting high byte, 1 = high byte held, expecting low byte
// ----------------------------------------------------------------------------
module dvp_byte_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] pix,
   output logic        pix_stb,
   output logic        phase
);

   logic [7:0] hi_byte;

   // Toggle between high and low byte on every accepted byte. Clearing wins
   // so that a dangling odd byte never leaks into the next line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= 1'b0;
         hi_byte <= 8'd0;
      end else if (clear) begin
         phase <= 1'b0;
      end else if (en) begin
         if (!phase) begin
            hi_byte <= data;
         end
         phase <= ~phase;
      end
   end

   assign pix     = {hi_byte, data};
   assign pix_stb = en & phase & ~clear;

endmodule

// File: rtl/cmos_capture.sv
// ----------------------------------------------------------------------------
// cmos_capture
// Camera front end: turns the 8-bit DVP stream (vsync/href/data) into RGB565
// pixels with sop/eop framing. Start-up frames are skipped after the sensor
// configuration completes. Over-long lines are cropped, and short lines,
// odd byte counts and early vsyncs raise frame_err, so that downstream only
// sees frames with correct framing.
//
// Ports:
//   clk        pixel clock (camera pclk)
//   rst_n      asynchronous active-low reset
//   cfg_done   sensor configuration complete (level)
//   cam_vsync  frame sync, rising edge starts a frame
//   cam_href   line valid
//   cam_data   DVP byte, high byte of each pixel first
//   dout_sop   first pixel of frame, qualified by dout_vld
//   dout_eop   last pixel of frame, qualified by dout_vld
//   dout_vld   pixel valid
//   dout       RGB565 pixel
//   frame_err  one-cycle pulse on a malformed line or frame
//   frame_cnt  frames delivered with eop, wraps at 255
// ----------------------------------------------------------------------------
module cmos_capture #(
   parameter int H_ACT       = 640,
   parameter int V_ACT       = 480,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_done,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic        dout_vld,
   output logic [15:0] dout,
   output logic        frame_err,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, ACTIVE} state_t;

   localparam logic [10:0] X_MAX  = 11'(H_ACT);
   localparam logic [10:0] Y_MAX  = 11'(V_ACT);
   localparam logic [10:0] X_LAST = 11'(H_ACT - 1);
   localparam logic [10:0] Y_LAST = 11'(V_ACT - 1);
   localparam logic [7:0]  SKIP_N = 8'(SKIP_FRAMES);

   state_t      state;
   logic [10:0] x_cnt;
   logic [10:0] y_cnt;
   logic [7:0]  skip_cnt;

   logic        vsync_r, vsync_r2;
   logic        href_r, href_r2;
   logic [7:0]  data_r;

   logic        vs_rise;
   logic        href_fall;
   logic        pack_en;
   logic        pack_clear;
   logic [15:0] pix;
   logic        pix_stb;
   logic        phase;
   logic        in_frame;
   logic        is_last;

   // Camera inputs are registered once; the second stage only exists to
   // find the vsync rising edge and the href falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_r  <= 1'b0;
         vsync_r2 <= 1'b0;
         href_r   <= 1'b0;
         href_r2  <= 1'b0;
         data_r   <= 8'd0;
      end else begin
         vsync_r  <= cam_vsync;
         vsync_r2 <= vsync_r;
         href_r   <= cam_href;
         href_r2  <= href_r;
         data_r   <= cam_data;
      end
   end

   assign vs_rise    = vsync_r & ~vsync_r2;
   assign href_fall  = ~href_r & href_r2;
   assign pack_en    = (state == ACTIVE) & href_r;
   assign pack_clear = href_fall | (state != ACTIVE);
   assign in_frame   = (x_cnt < X_MAX) && (y_cnt < Y_MAX);
   assign is_last    = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

   dvp_byte_pack u_pack (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (pack_clear),
      .en      (pack_en),
      .data    (data_r),
      .pix     (pix),
      .pix_stb (pix_stb),
      .phase   (phase)
   );

   // Capture FSM with registered outputs. Losing cfg_done abandons whatever
   // is in flight without an error, because the sensor is being reprogrammed
   // rather than misbehaving. An early vsync in ACTIVE is consumed: the FSM
   // waits for the following frame rather than starting on a torn one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x_cnt     <= 11'd0;
         y_cnt     <= 11'd0;
         skip_cnt  <= 8'd0;
         dout      <= 16'd0;
         dout_vld  <= 1'b0;
         dout_sop  <= 1'b0;
         dout_eop  <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         dout_vld  <= 1'b0;
         dout_sop  <= 1'b0;
         dout_eop  <= 1'b0;
         frame_err <= 1'b0;
         if (!cfg_done) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  skip_cnt <= 8'd0;
                  state    <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
               end
               SKIP: begin
                  if (vs_rise) begin
                     skip_cnt <= skip_cnt + 8'd1;
                     if (skip_cnt + 8'd1 >= SKIP_N) begin
                        state <= WAIT_VS;
                     end
                  end
               end
               WAIT_VS: begin
                  if (vs_rise) begin
                     x_cnt <= 11'd0;
                     y_cnt <= 11'd0;
                     state <= ACTIVE;
                  end
               end
               ACTIVE: begin
                  if (vs_rise) begin
                     frame_err <= 1'b1;
                     state     <= WAIT_VS;
                  end else begin
                     if (pix_stb) begin
                        if (x_cnt < X_MAX) begin
                           x_cnt <= x_cnt + 11'd1;
                        end
                        if (in_frame) begin
                           dout     <= pix;
                           dout_vld <= 1'b1;
                           dout_sop <= (x_cnt == 11'd0) && (y_cnt == 11'd0);
                           dout_eop <= is_last;
                           if (is_last) begin
                              frame_cnt <= frame_cnt + 8'd1;
                              state     <= WAIT_VS;
                           end
                        end
                     end
                     // A line ends: odd byte count or a short visible line
                     // are both reported, over-long lines were cropped above.
                     if (href_fall) begin
                        x_cnt <= 11'd0;
                        if (y_cnt < Y_MAX) begin
                           y_cnt <= y_cnt + 11'd1;
                        end
                        if (phase || in_frame) begin
                           frame_err <= 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmos_capture.sv
// ----------------------------------------------------------------------------
// tb_cmos_capture
// Directed bench for cmos_capture with an 8x4 frame and two skipped frames.
// A monitor on the falling edge keeps running totals of pixels, sop, eop and
// error pulses plus a log of pixel values; each scenario compares the change
// in those totals against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_cmos_capture;

   localparam int H = 8;
   localparam int V = 4;
   localparam int SKIP = 2;

   logic        clk;
   logic        rst_n;
   logic        cfg_done;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        dout_sop;
   logic        dout_eop;
   logic        dout_vld;
   logic [15:0] dout;
   logic        frame_err;
   logic [7:0]  frame_cnt;

   int checks;
   int failures;

   int          vld_total;
   int          sop_total;
   int          eop_total;
   int          err_total;
   logic [15:0] pix_log [0:2047];

   cmos_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_done  (cfg_done),
      .cam_vsync (cam_vsync),
      .cam_href  (cam_href),
      .cam_data  (cam_data),
      .dout_sop  (dout_sop),
      .dout_eop  (dout_eop),
      .dout_vld  (dout_vld),
      .dout      (dout),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output monitor, sampled on the falling edge away from register updates.
   initial begin
      vld_total = 0;
      sop_total = 0;
      eop_total = 0;
      err_total = 0;
      forever begin
         @(negedge clk);
         if (dout_vld) begin
            if (vld_total < 2048) pix_log[vld_total] = dout;
            vld_total = vld_total + 1;
            if (dout_sop) sop_total = sop_total + 1;
            if (dout_eop) eop_total = eop_total + 1;
         end
         if (frame_err) err_total = err_total + 1;
      end
   end

   // Frame sync pulse followed by a short blanking gap.
   task automatic send_vsync();
      @(negedge clk);
      cam_vsync = 1'b1;
      repeat (2) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // One line of nbytes bytes: pixel k carries hi = tag, lo = k.
   task automatic send_line(input int nbytes, input logic [7:0] tag);
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         cam_href = 1'b1;
         cam_data = (i % 2 == 0) ? tag : 8'(i / 2);
      end
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] tag_base);
      send_vsync();
      for (int l = 0; l < V; l++) begin
         send_line(2 * H, tag_base + 8'(l));
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cfg_done  = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      repeat (3) @(negedge clk);
      checks = checks + 1;
      if ({dout_vld, dout_sop, dout_eop, frame_err} !== 4'b0000) begin
         failures = failures + 1;
         $display("[TB] FAIL reset_flags got=%b want=0000", {dout_vld, dout_sop, dout_eop, frame_err});
      end
      checks = checks + 1;
      if (dout !== 16'h0000 || frame_cnt !== 8'h00) begin
         failures = failures + 1;
         $display("[TB] FAIL reset_data dout=%h frame_cnt=%0d want 0000/0", dout, frame_cnt);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_skip();
      int v0, s0, e0, r0;
      cfg_done = 1'b1;
      repeat (3) @(negedge clk);
      v0 = vld_total;
      r0 = err_total;
      send_frame(8'h10);
      send_frame(8'h20);
      checks = checks + 1;
      if (vld_total - v0 !== 0 || err_total - r0 !== 0) begin
         failures = failures + 1;
         $display("[TB] FAIL skip_quiet vld=%0d err=%0d want 0/0", vld_total - v0, err_total - r0);
      end
      for (int f = 0; f < 2; f++) begin
         v0 = vld_total; s0 = sop_total; e0 = eop_total; r0 = err_total;
         send_frame(8'h30 + 8'(f * 16));
         checks = checks + 1;
         if (vld_total - v0 !== 32 || sop_total - s0 !== 1 || eop_total - e0 !== 1 || err_total - r0 !== 0) begin
            failures = failures + 1;
            $display("[TB] FAIL frame%0d_counts vld=%0d sop=%0d eop=%0d err=%0d want 32/1/1/0",
                     f + 3, vld_total - v0, sop_total - s0, eop_total - e0, err_total - r0);
         end
         checks = checks + 1;
         if (pix_log[v0] !== {8'h30 + 8'(f * 16), 8'h00} || pix_log[v0 + 31] !== {8'h33 + 8'(f * 16), 8'h07}) begin
            failures = failures + 1;
            $display("[TB] FAIL frame%0d_pixels first=%h last=%h want %h/%h", f + 3, pix_log[v0],
                     pix_log[v0 + 31], {8'h30 + 8'(f * 16), 8'h00}, {8'h33 + 8'(f * 16), 8'h07});
         end
      end
      checks = checks + 1;
      if (frame_cnt !== 8'd2) begin
         failures = failures + 1;
         $display("[TB] FAIL skip_frame_cnt got=%0d want=2", frame_cnt);
      end
   endtask

   task automatic test_latency();
      logic early_vld;
      send_vsync();
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'hF8;
      @(negedge clk);
      cam_data = 8'h1F;
      @(posedge clk);
      #1 early_vld = dout_vld;
      @(negedge clk);
      cam_data = 8'hA0;
      @(posedge clk);
      #1;
      checks = checks + 1;
      if (early_vld !== 1'b0 || dout_vld !== 1'b1 || dout !== 16'hF81F || dout_sop !== 1'b1) begin
         failures = failures + 1;
         $display("[TB] FAIL latency early=%b vld=%b dout=%h sop=%b want 0/1/f81f/1",
                  early_vld, dout_vld, dout, dout_sop);
      end
      for (int i = 3; i < 2 * H; i++) begin
         @(negedge clk);
         cam_data = (i % 2 == 0) ? 8'hA0 : 8'(i / 2);
      end
      @(negedge clk);
      cam_href = 1'b0;
      repeat (4) @(negedge clk);
      for (int l = 1; l < V; l++) begin
         send_line(2 * H, 8'hA0 + 8'(l));
      end
      checks = checks + 1;
      if (frame_cnt !== 8'd3) begin
         failures = failures + 1;
         $display("[TB] FAIL latency_frame_cnt got=%0d want=3", frame_cnt);
      end
   endtask

   task automatic test_line_length();
      int v0, e0, r0;
      send_vsync();
      v0 = vld_total; r0 = err_total;
      send_line(20, 8'h40);
      checks = checks + 1;
      if (vld_total - v0 !== 8 || err_total - r0 !== 0) begin
         failures = failures + 1;
         $display("[TB] FAIL long_line vld=%0d err=%0d want 8/0", vld_total - v0, err_total - r0);
      end
      v0 = vld_total; r0 = err_total; e0 = eop_total;
      send_line(12, 8'h41);
      checks = checks + 1;
      if (vld_total - v0 !== 6 || err_total - r0 !== 1) begin
         failures = failures + 1;
         $display("[TB] FAIL short_line vld=%0d err=%0d want 6/1", vld_total - v0, err_total - r0);
      end
      send_line(2 * H, 8'h42);
      send_line(2 * H, 8'h43);
      checks = checks + 1;
      if (eop_total - e0 !== 1 || frame_cnt !== 8'd4 || pix_log[vld_total - 1] !== 16'h4307) begin
         failures = failures + 1;
         $display("[TB] FAIL short_frame_end eop=%0d frame_cnt=%0d last=%h want 1/4/4307",
                  eop_total - e0, frame_cnt, pix_log[vld_total - 1]);
      end
   endtask

   task automatic test_odd_bytes();
      int v0, r0;
      send_vsync();
      v0 = vld_total; r0 = err_total;
      send_line(17, 8'h50);
      checks = checks + 1;
      if (vld_total - v0 !== 8 || err_total - r0 !== 1) begin
         failures = failures + 1;
         $display("[TB] FAIL odd_line vld=%0d err=%0d want 8/1", vld_total - v0, err_total - r0);
      end
      v0 = vld_total; r0 = err_total;
      send_line(2 * H, 8'h55);
      checks = checks + 1;
      if (vld_total - v0 !== 8 || err_total - r0 !== 0 || pix_log[v0] !== 16'h5500 || pix_log[v0 + 7] !== 16'h5507) begin
         failures = failures + 1;
         $display("[TB] FAIL odd_next_line vld=%0d err=%0d first=%h last=%h want 8/0/5500/5507",
                  vld_total - v0, err_total - r0, pix_log[v0], pix_log[v0 + 7]);
      end
      send_line(2 * H, 8'h56);
      send_line(2 * H, 8'h57);
      checks = checks + 1;
      if (frame_cnt !== 8'd5) begin
         failures = failures + 1;
         $display("[TB] FAIL odd_frame_cnt got=%0d want=5", frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int v0, e0, r0;
      send_vsync();
      send_line(2 * H, 8'h60);
      send_line(2 * H, 8'h61);
      e0 = eop_total; r0 = err_total;
      send_vsync();
      checks = checks + 1;
      if (err_total - r0 !== 1 || eop_total - e0 !== 0 || frame_cnt !== 8'd5) begin
         failures = failures + 1;
         $display("[TB] FAIL early_vsync err=%0d eop=%0d frame_cnt=%0d want 1/0/5",
                  err_total - r0, eop_total - e0, frame_cnt);
      end
      v0 = vld_total; e0 = eop_total; r0 = err_total;
      send_frame(8'h70);
      checks = checks + 1;
      if (vld_total - v0 !== 32 || eop_total - e0 !== 1 || err_total - r0 !== 0 ||
          frame_cnt !== 8'd6 || pix_log[v0] !== 16'h7000) begin
         failures = failures + 1;
         $display("[TB] FAIL after_abort vld=%0d eop=%0d err=%0d frame_cnt=%0d first=%h want 32/1/0/6/7000",
                  vld_total - v0, eop_total - e0, err_total - r0, frame_cnt, pix_log[v0]);
      end
   endtask

   task automatic test_cfg_drop();
      int r0;
      int late_vld;
      late_vld = 0;
      send_vsync();
      send_line(2 * H, 8'h80);
      r0 = err_total;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cam_href = 1'b1;
         cam_data = (i % 2 == 0) ? 8'h81 : 8'(i / 2);
      end
      @(negedge clk);
      cfg_done = 1'b0;
      cam_data = 8'h81;
      for (int i = 7; i < 2 * H; i++) begin
         @(posedge clk);
         #1 if (dout_vld) late_vld = late_vld + 1;
         @(negedge clk);
         cam_data = (i % 2 == 0) ? 8'h81 : 8'(i / 2);
      end
      @(negedge clk);
      cam_href = 1'b0;
      repeat (6) @(negedge clk);
      checks = checks + 1;
      if (late_vld !== 0 || err_total - r0 !== 0 || frame_cnt !== 8'd6) begin
         failures = failures + 1;
         $display("[TB] FAIL cfg_drop late_vld=%0d err=%0d frame_cnt=%0d want 0/0/6",
                  late_vld, err_total - r0, frame_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      int v0;
      cfg_done = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'h90);
      send_frame(8'h94);
      send_vsync();
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'hC3;
      @(negedge clk);
      cam_data = 8'h3C;
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks = checks + 1;
      if ({dout_vld, dout_sop, dout_eop, frame_err} !== 4'b0000 || dout !== 16'h0000 || frame_cnt !== 8'd0) begin
         failures = failures + 1;
         $display("[TB] FAIL midframe_reset flags=%b dout=%h frame_cnt=%0d want 0000/0000/0",
                  {dout_vld, dout_sop, dout_eop, frame_err}, dout, frame_cnt);
      end
      @(negedge clk);
      cam_href = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      v0 = vld_total;
      send_frame(8'hB0);
      send_frame(8'hB4);
      checks = checks + 1;
      if (vld_total - v0 !== 0) begin
         failures = failures + 1;
         $display("[TB] FAIL post_reset_skip vld=%0d want 0", vld_total - v0);
      end
      send_frame(8'hC0);
      checks = checks + 1;
      if (vld_total - v0 !== 32 || frame_cnt !== 8'd1 || pix_log[v0] !== 16'hC000) begin
         failures = failures + 1;
         $display("[TB] FAIL post_reset_frame vld=%0d frame_cnt=%0d first=%h want 32/1/c000",
                  vld_total - v0, frame_cnt, pix_log[v0]);
      end
   endtask

   // Scenario sequence; every scenario is bounded by fixed cycle counts.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_skip();
      test_latency();
      test_line_length();
      test_odd_bytes();
      test_back_to_back();
      test_cfg_drop();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
